// File: rtl/ava_bram_pkg.sv
// Shared types and helpers for the ava block-RAM family.
// lane_merge is written against the widest supported word so one copy serves every instance width.
package ava_bram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST  = 2'd0,
        RDW_WRITE_FIRST = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_t;

    localparam int MAX_WORD_WIDTH = 256;
    localparam int MAX_LANES      = MAX_WORD_WIDTH;
    localparam int MAX_IDX_W      = $clog2(MAX_WORD_WIDTH);

    // Callers zero-extend into the wide arguments and truncate the result back to their width.
    function automatic logic [MAX_WORD_WIDTH-1:0] lane_merge(
        input logic [MAX_WORD_WIDTH-1:0] oldWord,
        input logic [MAX_WORD_WIDTH-1:0] newWord,
        input logic [MAX_LANES-1:0]      laneWe,
        input int unsigned               gran
    );
        logic [MAX_WORD_WIDTH-1:0] merged;
        merged = oldWord;
        for (int unsigned b = 0; b < MAX_WORD_WIDTH; b++) begin
            if (laneWe[MAX_IDX_W'(b / gran)]) begin
                merged[MAX_IDX_W'(b)] = newWord[MAX_IDX_W'(b)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ava_bram_outreg.sv
// Data plus valid register behind a RAM read port; data only loads with valid so
// the held output survives idle cycles, matching a BRAM output register with CE.
module ava_bram_outreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/ava_tdpbram.sv
// True dual-port block RAM with per-lane write enables, selectable same-port
// read-during-write behaviour, read-valid strobes and an optional output register.
module ava_tdpbram
    import ava_bram_pkg::*;
#(
    parameter int        WORD_COUNT   = 1024,
    parameter int        WORD_WIDTH   = 32,
    parameter int        GRANULARITY  = 8,
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_t RDW_MODE     = RDW_READ_FIRST,
    localparam int       GRAN_CNT     = WORD_WIDTH / GRANULARITY,
    localparam int       ADDR_WIDTH   = $clog2(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [WORD_WIDTH-1:0] di1,
    input  logic                  en1,
    input  logic [GRAN_CNT-1:0]   we1,
    output logic [WORD_WIDTH-1:0] do1,
    output logic                  dv1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [WORD_WIDTH-1:0] di2,
    input  logic                  en2,
    input  logic [GRAN_CNT-1:0]   we2,
    output logic [WORD_WIDTH-1:0] do2,
    output logic                  dv2
);

    if (WORD_WIDTH % GRANULARITY != 0) begin : g_chkGran
        $error("ava_tdpbram: WORD_WIDTH must be a multiple of GRANULARITY");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chkLat
        $error("ava_tdpbram: READ_LATENCY must be 1 or 2");
    end
    if (WORD_COUNT < 2 || (WORD_COUNT & (WORD_COUNT - 1)) != 0) begin : g_chkCount
        $error("ava_tdpbram: WORD_COUNT must be a power of two and at least 2");
    end
    if (WORD_WIDTH > MAX_WORD_WIDTH) begin : g_chkWidth
        $error("ava_tdpbram: WORD_WIDTH exceeds the lane_merge helper width");
    end

    localparam bit IS_WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);
    localparam bit IS_NO_CHANGE   = (RDW_MODE == RDW_NO_CHANGE);

    logic [WORD_WIDTH-1:0] w_old1;
    logic [WORD_WIDTH-1:0] w_old2;
    logic [WORD_WIDTH-1:0] w_merge1;
    logic [WORD_WIDTH-1:0] w_merge2;
    logic                  w_wr1;
    logic                  w_wr2;

    logic [WORD_WIDTH-1:0] r_do1;
    logic [WORD_WIDTH-1:0] r_do2;
    logic                  r_dv1;
    logic                  r_dv2;

    // One narrow array per lane; port 1 is assigned last so it wins a same-lane collision.
    for (genvar g = 0; g < GRAN_CNT; g++) begin : g_lane
        (* ram_style = "block" *) logic [GRANULARITY-1:0] r_mem [WORD_COUNT];

        always_ff @(posedge clk) begin
            if (!rst) begin
                if (en2 && we2[g]) begin
                    r_mem[a2] <= di2[g*GRANULARITY +: GRANULARITY];
                end
                if (en1 && we1[g]) begin
                    r_mem[a1] <= di1[g*GRANULARITY +: GRANULARITY];
                end
            end
        end

        assign w_old1[g*GRANULARITY +: GRANULARITY] = r_mem[a1];
        assign w_old2[g*GRANULARITY +: GRANULARITY] = r_mem[a2];
    end

    assign w_wr1 = (we1 != '0);
    assign w_wr2 = (we2 != '0);

    assign w_merge1 = WORD_WIDTH'(lane_merge(MAX_WORD_WIDTH'(w_old1), MAX_WORD_WIDTH'(di1),
                                             MAX_LANES'(we1), GRANULARITY));
    assign w_merge2 = WORD_WIDTH'(lane_merge(MAX_WORD_WIDTH'(w_old2), MAX_WORD_WIDTH'(di2),
                                             MAX_LANES'(we2), GRANULARITY));

    // Reads sample the array before this edge's writes, so the other port always sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_do1 <= '0;
            r_dv1 <= 1'b0;
        end else if (en1) begin
            if (w_wr1 && IS_NO_CHANGE) begin
                r_dv1 <= 1'b0;
            end else begin
                r_dv1 <= 1'b1;
                r_do1 <= (w_wr1 && IS_WRITE_FIRST) ? w_merge1 : w_old1;
            end
        end else begin
            r_dv1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_do2 <= '0;
            r_dv2 <= 1'b0;
        end else if (en2) begin
            if (w_wr2 && IS_NO_CHANGE) begin
                r_dv2 <= 1'b0;
            end else begin
                r_dv2 <= 1'b1;
                r_do2 <= (w_wr2 && IS_WRITE_FIRST) ? w_merge2 : w_old2;
            end
        end else begin
            r_dv2 <= 1'b0;
        end
    end

    if (READ_LATENCY == 2) begin : g_outreg
        ava_bram_outreg #(.WIDTH(WORD_WIDTH)) u_outreg1 (
            .clk     (clk),
            .rst     (rst),
            .i_data  (r_do1),
            .i_valid (r_dv1),
            .o_data  (do1),
            .o_valid (dv1)
        );
        ava_bram_outreg #(.WIDTH(WORD_WIDTH)) u_outreg2 (
            .clk     (clk),
            .rst     (rst),
            .i_data  (r_do2),
            .i_valid (r_dv2),
            .o_data  (do2),
            .o_valid (dv2)
        );
    end else begin : g_direct
        assign do1 = r_do1;
        assign dv1 = r_dv1;
        assign do2 = r_do2;
        assign dv2 = r_dv2;
    end

endmodule

// File: tb/tb_ava_tdpbram.sv
// Drives one shared stimulus stream into all six RDW_MODE x READ_LATENCY variants and
// scores each against a word-level memory model through per-port expectation queues.
module tb_ava_tdpbram;
    import ava_bram_pkg::*;

    localparam int WC    = 64;
    localparam int AW    = 6;
    localparam int WW    = 32;
    localparam int GC    = 4;
    localparam int NINST = 6;

    typedef struct {
        int            due;
        logic [WW-1:0] data;
        bit            chk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] a1  = '0;
    logic [AW-1:0] a2  = '0;
    logic [WW-1:0] di1 = '0;
    logic [WW-1:0] di2 = '0;
    logic          en1 = 1'b0;
    logic          en2 = 1'b0;
    logic [GC-1:0] we1 = '0;
    logic [GC-1:0] we2 = '0;

    logic [WW-1:0] doOut [NINST][2];
    logic          dvOut [NINST][2];

    int  checks    = 0;
    int  errors    = 0;
    int  cyc       = 0;
    int  rstEdge   = -1;
    bit  initPhase = 1'b1;

    exp_t          expQ    [NINST][2][$];
    logic [WW-1:0] memModel[WC];
    logic [WW-1:0] holdDo  [NINST][2];
    bit            holdChk [NINST][2];

    always #5 clk = ~clk;

    // Instance index k = mode*2 + (latency-1)
    for (genvar m = 0; m < 3; m++) begin : g_mode
        for (genvar l = 0; l < 2; l++) begin : g_lat
            ava_tdpbram #(
                .WORD_COUNT   (WC),
                .WORD_WIDTH   (WW),
                .GRANULARITY  (8),
                .READ_LATENCY (l + 1),
                .RDW_MODE     (rdw_mode_t'(m))
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .a1  (a1),
                .di1 (di1),
                .en1 (en1),
                .we1 (we1),
                .do1 (doOut[m*2+l][0]),
                .dv1 (dvOut[m*2+l][0]),
                .a2  (a2),
                .di2 (di2),
                .en2 (en2),
                .we2 (we2),
                .do2 (doOut[m*2+l][1]),
                .dv2 (dvOut[m*2+l][1])
            );
        end
    end

    function automatic logic [WW-1:0] merge32(logic [WW-1:0] o, logic [WW-1:0] n, logic [GC-1:0] w);
        return WW'(lane_merge(MAX_WORD_WIDTH'(o), MAX_WORD_WIDTH'(n), MAX_LANES'(w), 8));
    endfunction

    task automatic checkOutput(string name, logic [WW-1:0] actual, logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic e1, input logic [GC-1:0] w1, input logic [AW-1:0] ad1, input logic [WW-1:0] d1,
                                 input logic e2, input logic [GC-1:0] w2, input logic [AW-1:0] ad2, input logic [WW-1:0] d2);
        @(negedge clk);
        rst = r;
        en1 = e1; we1 = w1; a1 = ad1; di1 = d1;
        en2 = e2; we2 = w2; a2 = ad2; di2 = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    // Lets the last read reach every variant's output, then compares the held data.
    task automatic expectAfterRead(int p, logic [WW-1:0] wfVal, logic [WW-1:0] otherVal, string name);
        idleCycles(1);
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            checkOutput($sformatf("%s inst%0d port%0d", name, k, p + 1), doOut[k][p],
                        (rdw_mode_t'(k / 2) == RDW_WRITE_FIRST) ? wfVal : otherVal);
        end
    endtask

    task automatic modelPort(int k, int p, logic en, logic [GC-1:0] we, logic [WW-1:0] di, logic [WW-1:0] old);
        exp_t      e;
        rdw_mode_t md;
        bit        wr;
        md = rdw_mode_t'(k / 2);
        wr = (we != '0);
        if (!en) return;
        if (wr && md == RDW_NO_CHANGE) return;
        e.due  = cyc + (k % 2);
        e.data = (wr && md == RDW_WRITE_FIRST) ? merge32(old, di, we) : old;
        e.chk  = !initPhase || (wr && md == RDW_WRITE_FIRST && we == '1);
        expQ[k][p].push_back(e);
    endtask

    // Reference model: every enabled port yields a word after its latency, writes land after both reads.
    initial forever begin
        logic [WW-1:0] old1;
        logic [WW-1:0] old2;
        @(posedge clk);
        cyc++;
        if (rst) begin
            rstEdge = cyc;
        end else begin
            old1 = memModel[a1];
            old2 = memModel[a2];
            for (int k = 0; k < NINST; k++) begin
                modelPort(k, 0, en1, we1, di1, old1);
                modelPort(k, 1, en2, we2, di2, old2);
            end
            if (en2) memModel[a2] = merge32(memModel[a2], di2, we2);
            if (en1) memModel[a1] = merge32(memModel[a1], di1, we1);
        end
    end

    task automatic checkPort(int k, int p);
        exp_t  e;
        string tag;
        tag = $sformatf("inst%0d mode%0d lat%0d port%0d", k, k / 2, k % 2 + 1, p + 1);
        if (rstEdge == cyc) begin
            expQ[k][p].delete();
            holdDo[k][p]  = '0;
            holdChk[k][p] = 1'b1;
            checkOutput({tag, " dv in reset"}, WW'(dvOut[k][p]), '0);
            checkOutput({tag, " do in reset"}, doOut[k][p], '0);
        end else if (expQ[k][p].size() != 0 && expQ[k][p][0].due == cyc) begin
            e = expQ[k][p].pop_front();
            checkOutput({tag, " dv"}, WW'(dvOut[k][p]), WW'(1));
            if (e.chk) checkOutput({tag, " data"}, doOut[k][p], e.data);
            holdDo[k][p]  = e.data;
            holdChk[k][p] = e.chk;
        end else begin
            checkOutput({tag, " idle dv"}, WW'(dvOut[k][p]), '0);
            if (holdChk[k][p]) checkOutput({tag, " held do"}, doOut[k][p], holdDo[k][p]);
        end
    endtask

    // Monitor: samples on the falling edge, away from the sampling edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            checkPort(k, 0);
            checkPort(k, 1);
        end
    end

    initial begin
        logic          r;
        logic          e1, e2;
        logic [GC-1:0] w1, w2;
        logic [AW-1:0] ad1, ad2;

        for (int k = 0; k < NINST; k++) begin
            holdChk[k][0] = 1'b0;
            holdChk[k][1] = 1'b0;
        end

        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

        // Give every word a known value before anything is compared.
        for (int i = 0; i < WC / 2; i++) begin
            applyStimulus(1'b0, 1'b1, '1, AW'(i), $urandom, 1'b1, '1, AW'(i + WC / 2), $urandom);
        end
        initPhase = 1'b0;

        // Accesses while in reset must neither write nor strobe.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, '1, 6'h10, 32'hBADC0FFE, 1'b1, '1, 6'h11, 32'h0BADF00D);
        end
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, '0, 6'h10, '0, 1'b1, '0, 6'h11, '0);
        expectAfterRead(0, memModel[6'h10], memModel[6'h10], "reset suppressed write");

        applyStimulus(1'b0, 1'b1, '1, 6'h05, 32'h11223344, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'b0010, 6'h05, 32'h0000AA00);
        applyStimulus(1'b0, 1'b1, '0, 6'h05, '0, 1'b0, '0, '0, '0);
        expectAfterRead(0, 32'h1122AA44, 32'h1122AA44, "lane write");

        applyStimulus(1'b0, 1'b1, '1, 6'h08, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, '0, 6'h08, '0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, '1, 6'h08, 32'hCAFEF00D, 1'b0, '0, '0, '0);
        expectAfterRead(0, 32'hCAFEF00D, 32'hDEADBEEF, "rdw");

        applyStimulus(1'b0, 1'b1, '1, 6'h20, 32'h0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 4'b0011, 6'h20, 32'hAAAAAAAA, 1'b1, 4'b0110, 6'h20, 32'h55555555);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h20, '0);
        expectAfterRead(1, 32'h0055AAAA, 32'h0055AAAA, "collision merge");
        applyStimulus(1'b0, 1'b1, '1, 6'h20, 32'h12345678, 1'b1, '0, 6'h20, '0);
        expectAfterRead(1, 32'h0055AAAA, 32'h0055AAAA, "cross-port old word");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h20, '0);
        expectAfterRead(1, 32'h12345678, 32'h12345678, "cross-port write landed");

        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h05, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h08, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h20, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h10, '0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h05, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0, 6'h08, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0, 6'h20, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0, 6'h10, '0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, 6'h08, '0);
        idleCycles(3);

        // Soak: narrow address window half the time to force collisions.
        for (int i = 0; i < 10000; i++) begin
            r   = ($urandom_range(0, 255) == 0);
            e1  = ($urandom_range(0, 3) != 0);
            e2  = ($urandom_range(0, 3) != 0);
            w1  = ($urandom_range(0, 3) == 0) ? '0 : GC'($urandom);
            w2  = ($urandom_range(0, 3) == 0) ? '0 : GC'($urandom);
            ad1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ad2 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            applyStimulus(r, e1, w1, ad1, $urandom, e2, w2, ad2, $urandom);
        end
        idleCycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ava_tdpbram.md
Name: ava_tdpbram

Overview:
Parametrised true dual-port block RAM. Both ports read and write, with per-granule write enables on each port. It adds a selectable read-during-write mode, an optional output pipeline register, read-valid strobes and defined cross-port collision rules. It is the common memory primitive for register files, caches and scratchpads that need two writable ports.

Parameters:
WORD_COUNT, 1024, number of words; power of two, >= 2.
WORD_WIDTH, 32, bits per word.
GRANULARITY, 8, bits per write-enable lane; WORD_WIDTH must be a multiple of it.
READ_LATENCY, 1, cycles from en to data; 1 = array register only, 2 = extra output register.
RDW_MODE, RDW_READ_FIRST, same-port read-during-write policy (ava_bram_pkg::rdw_mode_t).
Derived (localparam): GRAN_CNT = WORD_WIDTH/GRANULARITY, ADDR_WIDTH = $clog2(WORD_COUNT).

Ports:
clk  in  1  clock; everything is on posedge.
rst  in  1  synchronous, active-high reset.
a1  in  ADDR_WIDTH  port 1 address.
di1  in  WORD_WIDTH  port 1 write data.
en1  in  1  port 1 access enable; gates both reads and writes.
we1  in  GRAN_CNT  port 1 lane write enables; effective only when en1=1.
do1  out  WORD_WIDTH  port 1 read data.
dv1  out  1  port 1 read-data valid.
a2, di2, en2, we2, do2, dv2: the port 2 equivalents, with identical widths and meanings.

Behaviour:
- Reset: while rst=1, do1/do2 <= 0, dv1/dv2 <= 0 and the internal pipeline registers are cleared. Writes are suppressed while rst=1. Memory contents are not reset.
- Write: on posedge with enN=1, each lane i with weN[i]=1 takes diN[i*GRANULARITY +: GRANULARITY] at aN. Lanes with weN[i]=0 keep their old value.
- Read: enN=1 is an access. The data appears on doN after READ_LATENCY cycles, and dvN=1 in that same cycle.
  - dvN is a one-cycle pulse per access; back-to-back accesses give continuous dvN.
  - When enN=0, doN holds its last value and dvN=0.
- Same-port read-during-write (enN=1, weN!=0):
  - RDW_READ_FIRST: doN shows the old word.
  - RDW_WRITE_FIRST: doN shows the merged word (new lanes where weN=1, old lanes elsewhere).
  - RDW_NO_CHANGE: doN keeps its previous value and dvN=0 for that access.
- Cross-port collision, same address and same cycle:
  - Port writes, other port reads: the reader gets the old word, regardless of RDW_MODE.
  - Both ports write the same lane: port 1 wins.
  - Disjoint lanes from the two ports merge.
- READ_LATENCY=2:
  - Stage-1 data/valid feed an output register; there is no stall or back-pressure.
  - rst flushes both stages, so no dvN pulse follows for accesses issued up to 2 cycles before reset.
- Reset mid-operation: an access in the cycle rst is asserted is dropped (no write, no dv). The first access with rst=0 behaves normally.
- Address wrap: not applicable; addresses are exactly ADDR_WIDTH bits.
- Elaboration checks: error if WORD_WIDTH % GRANULARITY != 0, READ_LATENCY not in {1,2}, or WORD_COUNT is not a power of two.
- Synthesis: the array carries ram_style "block". The output register maps onto the BRAM output register when READ_LATENCY=2.

Decomposition:
- ava_bram_pkg:
  - typedef enum rdw_mode_t {RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE}.
  - function lane_merge(old, new, we) for granule masking, shared with the model in the bench.
- Sub-module ava_bram_outreg: a parametrised data+valid register with synchronous reset. It is instantiated once per port when READ_LATENCY=2.
- The array and both port processes stay in ava_tdpbram.

Test Plan:
1. Reset: drive rst=1 for 3 cycles with en1=en2=1 and we1=4'hF at a1=0x10 -> do1=do2=0 and dv=0 throughout. A later read of 0x10 does not return di1.
2. Byte lanes: write 0x11223344 to 0x05 via port 1, then port 2 writes we2=4'b0010 di2=0x0000AA00 -> port 1 read returns 0x1122AA44 with dv1 after READ_LATENCY cycles.
3. RDW modes: word 0x08=0xDEADBEEF, port 1 writes 0xCAFEF00D with we1=4'hF -> do1=0xDEADBEEF (READ_FIRST), 0xCAFEF00D (WRITE_FIRST), previous do1 with dv1=0 (NO_CHANGE).
4. Collision: both ports write 0x20 in one cycle, port 1 0xAAAAAAAA we=4'b0011, port 2 0x55555555 we=4'b0110 -> stored word 0x0055AAAA when the old word is 0. A same-cycle port 2 read during a port 1 write returns the old word.
5. Latency 2: issue 4 back-to-back reads on port 2 -> dv2 is high for cycles 2 to 5 and data is in order. Assert rst in cycle 2 -> dv2 stays 0 through cycle 5, and any later dv2 comes only from new accesses.
6. Random soak: 10k cycles of random en/we/addr on both ports against a package-function reference model, for every RDW_MODE x READ_LATENCY combination -> zero mismatches.
